// File: rtl/axi_fft_master.sv
// axi_fft_master
// AXI initiator for the FFT AXI bridge. Each accepted start pushes one INCR
// burst of 16-bit samples over AW/W/B, then fetches one INCR burst of results
// over AR/R.
//
// Ports
//   i_clk, i_rst          clock (rising edge), synchronous active-high reset
//   i_START               start pulse, sampled only while idle
//   i_BASE_ADDR, i_LEN    byte address and beats-1, shared by both bursts
//   i_S_DATA/VALID,
//   o_S_READY             sample stream in, passed straight onto W
//   o_M_DATA/VALID,
//   i_M_READY             result stream out, passed straight from R
//   AW/W/B, AR/R          AXI initiator channels
//   o_BUSY                high whenever a transaction pair is in flight
//   o_DONE                one-cycle completion pulse
//   o_ERR                 sticky response/framing error, cleared on start
module axi_fft_master #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_W_WIDTH = 2,
  parameter int                    ID_R_WIDTH = 2,
  parameter logic [2:0]            AXSIZE     = 3'd1,
  parameter logic [ID_W_WIDTH-1:0] W_ID       = 2'd1,
  parameter logic [ID_R_WIDTH-1:0] R_ID       = 2'd2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_START,
  input  logic [11:0]           i_BASE_ADDR,
  input  logic [7:0]            i_LEN,
  input  logic [15:0]           i_S_DATA,
  input  logic                  i_S_VALID,
  output logic                  o_S_READY,
  output logic [DATA_WIDTH-1:0] o_M_DATA,
  output logic                  o_M_VALID,
  input  logic                  i_M_READY,
  output logic [11:0]           o_AWADDR,
  output logic [7:0]            o_AWLEN,
  output logic [2:0]            o_AWSIZE,
  output logic [1:0]            o_AWBURST,
  output logic [ID_W_WIDTH-1:0] o_AWID,
  output logic                  o_AWVALID,
  input  logic                  i_AWREADY,
  output logic [15:0]           o_WDATA,
  output logic [1:0]            o_WSTRB,
  output logic                  o_WLAST,
  output logic                  o_WVALID,
  input  logic                  i_WREADY,
  input  logic                  i_BVALID,
  input  logic [ID_W_WIDTH-1:0] i_BID,
  output logic                  o_BREADY,
  output logic [11:0]           o_ARADDR,
  output logic [7:0]            o_ARLEN,
  output logic [2:0]            o_ARSIZE,
  output logic [1:0]            o_ARBURST,
  output logic [ID_R_WIDTH-1:0] o_ARID,
  output logic                  o_ARVALID,
  input  logic                  i_ARREADY,
  input  logic [DATA_WIDTH-1:0] i_RDATA,
  input  logic [ID_R_WIDTH-1:0] i_RID,
  input  logic                  i_RLAST,
  input  logic                  i_RVALID,
  output logic                  o_RREADY,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic                  o_ERR
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_beat;
  logic [7:0]  w_beat_next;
  logic [11:0] r_addr;
  logic [7:0]  r_len;
  logic        r_err;
  logic        w_err_next;
  logic        w_last;

  // The same beat counter frames both bursts; it is cleared between them.
  assign w_last = (r_beat == r_len);

  // State, beat counter and sticky error; address/length latched on start.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_beat  <= 8'd0;
      r_addr  <= 12'd0;
      r_len   <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_beat  <= w_beat_next;
      r_err   <= w_err_next;
      if ((r_state == S_IDLE) && i_START) begin
        r_addr <= i_BASE_ADDR;
        r_len  <= i_LEN;
      end else begin
        r_addr <= r_addr;
        r_len  <= r_len;
      end
    end
  end

  // Next-state logic and per-state channel drive.
  always_comb begin
    w_next      = r_state;
    w_beat_next = r_beat;
    w_err_next  = r_err;
    o_AWVALID   = 1'b0;
    o_WVALID    = 1'b0;
    o_S_READY   = 1'b0;
    o_WDATA     = 16'h0000;
    o_WLAST     = 1'b0;
    o_BREADY    = 1'b0;
    o_ARVALID   = 1'b0;
    o_RREADY    = 1'b0;
    o_M_VALID   = 1'b0;
    o_M_DATA    = {DATA_WIDTH{1'b0}};
    o_DONE      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_START) begin
          w_next      = S_AW;
          w_beat_next = 8'd0;
          w_err_next  = 1'b0;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_AW: begin
        o_AWVALID = 1'b1;
        if (i_AWREADY) begin
          w_next = S_W;
        end else begin
          w_next = S_AW;
        end
      end
      S_W: begin
        // The source handshake is forwarded onto W, so a stalled source
        // simply leaves a gap between beats.
        o_WVALID  = i_S_VALID;
        o_S_READY = i_WREADY;
        o_WDATA   = i_S_DATA;
        o_WLAST   = w_last;
        if (i_S_VALID && i_WREADY) begin
          if (w_last) begin
            w_next      = S_B;
            w_beat_next = 8'd0;
          end else begin
            w_beat_next = r_beat + 8'd1;
          end
        end else begin
          w_next = S_W;
        end
      end
      S_B: begin
        o_BREADY = 1'b1;
        if (i_BVALID) begin
          w_next = S_AR;
          if (i_BID != W_ID) begin
            w_err_next = 1'b1;
          end else begin
            w_err_next = r_err;
          end
        end else begin
          w_next = S_B;
        end
      end
      S_AR: begin
        o_ARVALID = 1'b1;
        if (i_ARREADY) begin
          w_next = S_R;
        end else begin
          w_next = S_AR;
        end
      end
      S_R: begin
        o_RREADY  = i_M_READY;
        o_M_VALID = i_RVALID;
        o_M_DATA  = i_RDATA;
        if (i_RVALID && i_M_READY) begin
          // RLAST must coincide with the expected final beat; either side
          // arriving alone ends the burst but flags an error.
          if ((i_RID != R_ID) || (i_RLAST != w_last)) begin
            w_err_next = 1'b1;
          end else begin
            w_err_next = r_err;
          end
          if (i_RLAST || w_last) begin
            w_next      = S_DONE;
            w_beat_next = 8'd0;
          end else begin
            w_beat_next = r_beat + 8'd1;
          end
        end else begin
          w_next = S_R;
        end
      end
      S_DONE: begin
        o_DONE = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next      = S_IDLE;
        w_beat_next = 8'd0;
      end
    endcase
  end

  assign o_AWADDR  = r_addr;
  assign o_AWLEN   = r_len;
  assign o_AWSIZE  = AXSIZE;
  assign o_AWBURST = 2'b01;
  assign o_AWID    = W_ID;
  assign o_WSTRB   = 2'b11;
  assign o_ARADDR  = r_addr;
  assign o_ARLEN   = r_len;
  assign o_ARSIZE  = AXSIZE;
  assign o_ARBURST = 2'b01;
  assign o_ARID    = R_ID;
  assign o_BUSY    = (r_state != S_IDLE);
  assign o_ERR     = r_err;

endmodule

// File: tb/tb_axi_fft_master.sv
module tb_axi_fft_master;

  logic        i_clk = 1'b0;
  logic        i_rst, i_START;
  logic [11:0] i_BASE_ADDR;
  logic [7:0]  i_LEN;
  logic [15:0] i_S_DATA;
  logic        i_S_VALID, o_S_READY;
  logic [31:0] o_M_DATA;
  logic        o_M_VALID, i_M_READY;
  logic [11:0] o_AWADDR, o_ARADDR;
  logic [7:0]  o_AWLEN, o_ARLEN;
  logic [2:0]  o_AWSIZE, o_ARSIZE;
  logic [1:0]  o_AWBURST, o_ARBURST, o_AWID, o_ARID, i_BID, i_RID, o_WSTRB;
  logic        o_AWVALID, i_AWREADY, o_WLAST, o_WVALID, i_WREADY;
  logic [15:0] o_WDATA;
  logic        i_BVALID, o_BREADY, o_ARVALID, i_ARREADY;
  logic [31:0] i_RDATA;
  logic        i_RLAST, i_RVALID, o_RREADY, o_BUSY, o_DONE, o_ERR;

  axi_fft_master dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_START(i_START), .i_BASE_ADDR(i_BASE_ADDR),
    .i_LEN(i_LEN), .i_S_DATA(i_S_DATA), .i_S_VALID(i_S_VALID), .o_S_READY(o_S_READY),
    .o_M_DATA(o_M_DATA), .o_M_VALID(o_M_VALID), .i_M_READY(i_M_READY),
    .o_AWADDR(o_AWADDR), .o_AWLEN(o_AWLEN), .o_AWSIZE(o_AWSIZE), .o_AWBURST(o_AWBURST),
    .o_AWID(o_AWID), .o_AWVALID(o_AWVALID), .i_AWREADY(i_AWREADY),
    .o_WDATA(o_WDATA), .o_WSTRB(o_WSTRB), .o_WLAST(o_WLAST), .o_WVALID(o_WVALID),
    .i_WREADY(i_WREADY), .i_BVALID(i_BVALID), .i_BID(i_BID), .o_BREADY(o_BREADY),
    .o_ARADDR(o_ARADDR), .o_ARLEN(o_ARLEN), .o_ARSIZE(o_ARSIZE), .o_ARBURST(o_ARBURST),
    .o_ARID(o_ARID), .o_ARVALID(o_ARVALID), .i_ARREADY(i_ARREADY),
    .i_RDATA(i_RDATA), .i_RID(i_RID), .i_RLAST(i_RLAST), .i_RVALID(i_RVALID),
    .o_RREADY(o_RREADY), .o_BUSY(o_BUSY), .o_DONE(o_DONE), .o_ERR(o_ERR)
  );

  always #5 i_clk = ~i_clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // mode: 0 zero-wait, 1 random waits, 2 WREADY stall + source gap, 3 M_READY toggling
  typedef struct {
    logic [11:0] base;
    logic [7:0]  len;
    logic [1:0]  bid;
    logic [1:0]  rid;
    int          rlast_idx;
    int          mode;
    bit          start_in_r;
    bit          exp_err;
    int          exp_nres;
    int          exp_cyc;
  } vec_t;

  // All outputs that must be low in IDLE.
  function automatic logic [10:0] idle_bits();
    return {o_AWVALID, o_WVALID, o_S_READY, o_WLAST, o_BREADY, o_ARVALID,
            o_RREADY, o_M_VALID, o_BUSY, o_DONE, o_ERR};
  endfunction

  task automatic run_txn(input int id, input vec_t v);
    logic [15:0] samp[$];
    logic [31:0] rdat[$];
    logic [15:0] w_got[$];
    logic [31:0] m_got[$];
    int  n_w, n_r, si, rk, cyc, done_cnt, done_cyc, aw_cnt, ar_cnt, b_cnt;
    int  wlast_cnt, wlast_at, b_state, b_wait, stall, tail;
    bit  gap_done, r_act, in_w, in_r, started_r, late_aw;
    bit  wpass_ok, rpass_ok, stable_ok, s_match_ok, aw_ok, ar_ok, busy_tail_ok, wd_ok, rd_ok;
    bit  aw_hs, w_hs, s_hs, b_hs, ar_hs, r_hs, m_hs, prev_stall;
    logic        prev_wlast;
    logic [15:0] prev_wdata;
    logic [2:0]  aw_view;
    logic        final_err;
    string       p;
    p = $sformatf("v%0d_", id);
    n_w = int'(v.len) + 1;
    n_r = (v.rlast_idx < int'(v.len)) ? v.rlast_idx + 1 : n_w;
    for (int i = 0; i < n_w; i++) samp.push_back(16'($urandom));
    for (int i = 0; i < 256; i++) rdat.push_back($urandom);
    si = 0; rk = 0; cyc = 0; done_cnt = 0; done_cyc = -1; aw_cnt = 0; ar_cnt = 0;
    b_cnt = 0; wlast_cnt = 0; wlast_at = -1; b_state = 0; b_wait = 0; stall = 0; tail = 0;
    gap_done = 0; r_act = 0; in_w = 0; in_r = 0; started_r = 0; late_aw = 0;
    wpass_ok = 1; rpass_ok = 1; stable_ok = 1; s_match_ok = 1; aw_ok = 1; ar_ok = 1;
    busy_tail_ok = 1; aw_hs = 0; w_hs = 0; s_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; m_hs = 0;
    prev_stall = 0; prev_wlast = 1'b0; prev_wdata = 16'h0; aw_view = 3'b000; final_err = 1'b0;
    i_S_VALID = 1'b0; i_RVALID = 1'b0; i_BVALID = 1'b0; i_RLAST = 1'b0;
    @(posedge i_clk); #1;
    i_BASE_ADDR = v.base;
    i_LEN       = v.len;
    while (tail < 4 && cyc < 3000) begin
      // ---- drive slave, source and sink for this cycle ----
      if (s_hs) si++;
      if (!(i_S_VALID && !s_hs)) begin
        if (si < n_w) begin
          case (v.mode)
            1: i_S_VALID = 1'($urandom_range(0, 1));
            2: if (si == 2 && !gap_done) begin i_S_VALID = 1'b0; gap_done = 1; end
               else i_S_VALID = 1'b1;
            default: i_S_VALID = 1'b1;
          endcase
        end else begin
          i_S_VALID = 1'b0;
        end
        i_S_DATA = i_S_VALID ? samp[si] : 16'($urandom);
      end
      i_AWREADY = (v.mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      i_ARREADY = (v.mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v.mode == 1) i_WREADY = 1'($urandom_range(0, 1));
      else if (v.mode == 2 && w_got.size() == 1 && stall < 2) begin i_WREADY = 1'b0; stall++; end
      else i_WREADY = 1'b1;
      if (b_hs) begin
        b_state = 3; i_BVALID = 1'b0;
      end else if (b_state == 0 && w_got.size() == n_w) begin
        b_state = 1; b_wait = (v.mode == 1) ? $urandom_range(0, 3) : 0;
      end
      if (b_state == 1) begin
        if (b_wait == 0) begin b_state = 2; i_BVALID = 1'b1; i_BID = v.bid; end
        else b_wait--;
      end
      if (ar_hs) r_act = 1;
      if (r_hs) rk++;
      if (done_cnt > 0) r_act = 0;
      if (!r_act || rk > 255) begin
        i_RVALID = 1'b0;
      end else if (!(i_RVALID && !r_hs)) begin
        i_RVALID = (v.mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        i_RDATA  = rdat[rk];
        i_RLAST  = (rk == v.rlast_idx);
        i_RID    = v.rid;
      end
      if (v.mode == 1) i_M_READY = 1'($urandom_range(0, 1));
      else if (v.mode == 3) i_M_READY = ~i_M_READY;
      else i_M_READY = 1'b1;
      i_START = (cyc == 0);
      if (v.start_in_r && in_r && !started_r) begin i_START = 1'b1; started_r = 1; end
      // ---- sample away from the clock edge ----
      @(negedge i_clk);
      if (cyc == 1) aw_view = {o_ERR, o_BUSY, o_AWVALID};
      if (o_AWVALID && ({o_AWADDR, o_AWLEN, o_AWSIZE, o_AWBURST, o_AWID} !==
                        {v.base, v.len, 3'd1, 2'b01, 2'd1})) aw_ok = 0;
      if (o_ARVALID && ({o_ARADDR, o_ARLEN, o_ARSIZE, o_ARBURST, o_ARID} !==
                        {v.base, v.len, 3'd1, 2'b01, 2'd2})) ar_ok = 0;
      if (in_w) begin
        if (o_WVALID !== i_S_VALID || o_S_READY !== i_WREADY || o_WSTRB !== 2'b11 ||
            (i_S_VALID && o_WDATA !== i_S_DATA) ||
            o_WLAST !== (w_got.size() == n_w - 1)) wpass_ok = 0;
        if (prev_stall && (!o_WVALID || o_WLAST !== prev_wlast || o_WDATA !== prev_wdata))
          stable_ok = 0;
      end
      if (in_r) begin
        if (o_M_VALID !== i_RVALID || o_RREADY !== i_M_READY ||
            (i_RVALID && o_M_DATA !== i_RDATA)) rpass_ok = 0;
      end
      prev_stall = o_WVALID && !i_WREADY;
      prev_wlast = o_WLAST;
      prev_wdata = o_WDATA;
      aw_hs = o_AWVALID && i_AWREADY;
      w_hs  = o_WVALID && i_WREADY;
      s_hs  = i_S_VALID && o_S_READY;
      b_hs  = i_BVALID && o_BREADY;
      ar_hs = o_ARVALID && i_ARREADY;
      r_hs  = i_RVALID && o_RREADY;
      m_hs  = o_M_VALID && i_M_READY;
      if (w_hs != s_hs) s_match_ok = 0;
      if (r_hs != m_hs) rpass_ok = 0;
      if (aw_hs) begin aw_cnt++; in_w = 1; end
      if (w_hs) begin
        w_got.push_back(o_WDATA);
        if (o_WLAST) begin wlast_cnt++; wlast_at = w_got.size() - 1; end
        if (w_got.size() >= n_w) in_w = 0;
      end
      if (b_hs) b_cnt++;
      if (ar_hs) begin ar_cnt++; in_r = 1; end
      if (m_hs) begin
        m_got.push_back(o_M_DATA);
        if (m_got.size() >= n_r) in_r = 0;
      end
      if (o_DONE) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cnt > 0) begin
        tail++;
        if (tail > 1 && o_BUSY) busy_tail_ok = 0;
        if (o_AWVALID) late_aw = 1;
        final_err = o_ERR;
      end
      @(posedge i_clk); cyc++; #1;
    end
    i_S_VALID = 1'b0; i_RVALID = 1'b0; i_BVALID = 1'b0; i_START = 1'b0;
    wd_ok = (w_got.size() == n_w);
    for (int i = 0; i < w_got.size() && i < n_w; i++) if (w_got[i] !== samp[i]) wd_ok = 0;
    rd_ok = (m_got.size() == v.exp_nres);
    for (int i = 0; i < m_got.size() && i < 256; i++) if (m_got[i] !== rdat[i]) rd_ok = 0;
    check({p, "done_count"}, done_cnt, 1);
    check({p, "aw_cycle_err_busy_valid"}, aw_view, 3'b011);
    check({p, "aw_count"}, aw_cnt, 1);
    check({p, "aw_fields"}, aw_ok, 1);
    check({p, "w_count"}, w_got.size(), n_w);
    check({p, "w_data"}, wd_ok, 1);
    check({p, "wlast_count"}, wlast_cnt, 1);
    check({p, "wlast_beat"}, wlast_at, n_w - 1);
    check({p, "w_passthrough"}, wpass_ok, 1);
    check({p, "w_stall_stable"}, stable_ok, 1);
    check({p, "w_source_match"}, s_match_ok, 1);
    check({p, "b_count"}, b_cnt, 1);
    check({p, "ar_count"}, ar_cnt, 1);
    check({p, "ar_fields"}, ar_ok, 1);
    check({p, "r_passthrough"}, rpass_ok, 1);
    check({p, "r_count"}, m_got.size(), v.exp_nres);
    check({p, "r_data"}, rd_ok, 1);
    check({p, "err"}, final_err, v.exp_err);
    check({p, "idle_after_no_aw"}, {busy_tail_ok, late_aw}, 2'b10);
    if (v.exp_cyc > 0) check({p, "done_cycle"}, done_cyc, v.exp_cyc);
  endtask

  task automatic reset_mid_w();
    int wcount;
    wcount = 0;
    i_AWREADY = 1'b1; i_WREADY = 1'b1; i_ARREADY = 1'b1; i_M_READY = 1'b1;
    i_S_VALID = 1'b1; i_S_DATA = 16'hABCD; i_BVALID = 1'b0; i_RVALID = 1'b0;
    i_BASE_ADDR = 12'h040; i_LEN = 8'd5;
    @(posedge i_clk); #1 i_START = 1'b1;
    @(posedge i_clk); #1 i_START = 1'b0;
    for (int i = 0; i < 20 && wcount < 2; i++) begin
      @(negedge i_clk);
      if (o_WVALID && i_WREADY) wcount++;
      @(posedge i_clk); #1;
    end
    check("rst_mid_w_reached_w", wcount, 2);
    i_rst = 1'b1;
    @(posedge i_clk); #1 i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_mid_w_outputs", idle_bits(), 11'd0);
    i_S_VALID = 1'b0;
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    i_rst = 1'b1; i_START = 1'b0; i_BASE_ADDR = 12'h0; i_LEN = 8'd0;
    i_S_DATA = 16'h0; i_S_VALID = 1'b0; i_M_READY = 1'b0; i_AWREADY = 1'b0;
    i_WREADY = 1'b0; i_BVALID = 1'b0; i_BID = 2'd0; i_ARREADY = 1'b0;
    i_RDATA = 32'h0; i_RID = 2'd0; i_RLAST = 1'b0; i_RVALID = 1'b0;
    // base, len, bid, rid, rlast_idx, mode, start_in_r, exp_err, exp_nres, exp_cyc
    tbl.push_back('{12'h000, 8'd3,   2'd1, 2'd2, 3,   0, 1'b0, 1'b0, 4,   12});
    tbl.push_back('{12'h100, 8'd0,   2'd1, 2'd2, 0,   0, 1'b0, 1'b0, 1,   6});
    tbl.push_back('{12'h7FE, 8'd7,   2'd1, 2'd2, 7,   0, 1'b1, 1'b0, 8,   20});
    tbl.push_back('{12'h000, 8'd3,   2'd1, 2'd2, 3,   2, 1'b0, 1'b0, 4,   0});
    tbl.push_back('{12'h020, 8'd7,   2'd1, 2'd2, 7,   3, 1'b0, 1'b0, 8,   0});
    tbl.push_back('{12'h000, 8'd3,   2'd0, 2'd2, 3,   0, 1'b0, 1'b1, 4,   12});
    tbl.push_back('{12'h010, 8'd3,   2'd1, 2'd2, 3,   0, 1'b0, 1'b0, 4,   12});
    tbl.push_back('{12'h000, 8'd3,   2'd1, 2'd2, 1,   0, 1'b0, 1'b1, 2,   10});
    tbl.push_back('{12'h000, 8'd3,   2'd1, 2'd2, 999, 0, 1'b0, 1'b1, 4,   12});
    tbl.push_back('{12'h004, 8'd2,   2'd1, 2'd3, 2,   0, 1'b0, 1'b1, 3,   10});
    tbl.push_back('{12'hFFE, 8'd255, 2'd1, 2'd2, 255, 0, 1'b0, 1'b0, 256, 516});
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check("reset_outputs", idle_bits(), 11'd0);
    check("reset_latched_addr_len", {o_AWADDR, o_AWLEN, o_ARADDR, o_ARLEN}, 40'd0);
    for (int i = 0; i < tbl.size(); i++) run_txn(i, tbl[i]);
    reset_mid_w();
    run_txn(100, tbl[0]);
    for (int i = 0; i < 12; i++) begin
      rv.base       = 12'($urandom);
      rv.len        = 8'($urandom_range(0, 15));
      rv.bid        = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd1;
      rv.rid        = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd2;
      rv.rlast_idx  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, int'(rv.len) + 2)
                                                  : int'(rv.len);
      rv.mode       = 1;
      rv.start_in_r = 1'($urandom_range(0, 1));
      // reference: any ID mismatch or RLAST not on beat LEN is an error;
      // the read burst ends at the earlier of RLAST and beat LEN
      rv.exp_err    = (rv.bid != 2'd1) || (rv.rid != 2'd2) || (rv.rlast_idx != int'(rv.len));
      rv.exp_nres   = (rv.rlast_idx < int'(rv.len)) ? rv.rlast_idx + 1 : int'(rv.len) + 1;
      rv.exp_cyc    = 0;
      run_txn(200 + i, rv);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
